// File: rtl/ide_pio_timed_if.sv
// ============================================================================
// Module   : ide_pio_timed_if
// Purpose  : Request-side and IDE-pin bundle for the timed IDE PIO engine.
//            Carries ide_iordy / iordy_tout when IDE_IORDY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ide_pio_timed_if #(
  parameter int DW = 16,
  parameter int AW = 3,
  parameter int TW = 4
);
  logic [TW-1:0] t1;
  logic [TW-1:0] t2;
  logic [TW-1:0] teoc;
  logic          rdy;
  logic          rdy_stb;
  logic [DW-1:0] rd_data;
  logic          dma_req;
  logic          dma_rnw;
  logic [DW-1:0] dma_out;
  logic          z80_req;
  logic          z80_rnw;
  logic [DW-1:0] z80_out;
  logic [AW-1:0] z80_a;
  logic          z80_cs0_n;
  logic          z80_cs1_n;
  logic [DW-1:0] ide_in;
  logic [DW-1:0] ide_out;
  logic [AW-1:0] ide_a;
  logic          ide_dir;
  logic          ide_cs0_n;
  logic          ide_cs1_n;
  logic          ide_rd_n;
  logic          ide_wr_n;
`ifdef IDE_IORDY_EN
  logic          ide_iordy;
  logic          iordy_tout;
`endif

  modport slave (
`ifdef IDE_IORDY_EN
    input  ide_iordy,
    output iordy_tout,
`endif
    input  t1, t2, teoc,
    input  dma_req, dma_rnw, dma_out,
    input  z80_req, z80_rnw, z80_out, z80_a, z80_cs0_n, z80_cs1_n,
    input  ide_in,
    output rdy, rdy_stb, rd_data,
    output ide_out, ide_a, ide_dir, ide_cs0_n, ide_cs1_n, ide_rd_n, ide_wr_n
  );

  modport master (
`ifdef IDE_IORDY_EN
    output ide_iordy,
    input  iordy_tout,
`endif
    output t1, t2, teoc,
    output dma_req, dma_rnw, dma_out,
    output z80_req, z80_rnw, z80_out, z80_a, z80_cs0_n, z80_cs1_n,
    output ide_in,
    input  rdy, rdy_stb, rd_data,
    input  ide_out, ide_a, ide_dir, ide_cs0_n, ide_cs1_n, ide_rd_n, ide_wr_n
  );
endinterface

`default_nettype wire

// File: rtl/ide_pio_timed.sv
// ============================================================================
// Module   : ide_pio_timed
// Purpose  : One-at-a-time IDE PIO cycle engine, DMA over Z80, with runtime
//            setup/strobe/recovery timing. IDE_IORDY_EN adds IORDY stretching.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ide_pio_timed #(
  parameter int DW       = 16,
  parameter int AW       = 3,
  parameter int TW       = 4,
  parameter int IORDY_TO = 255
) (
  input  logic          clk,
  input  logic          reset,
  ide_pio_timed_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, RECOVER} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] t2_q, t2_d;
  logic [TW-1:0] teoc_q, teoc_d;
  logic          rnw_q, rnw_d;
  logic [DW-1:0] ide_out_q, ide_out_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic [AW-1:0] ide_a_q, ide_a_d;
  logic          ide_dir_q, ide_dir_d;
  logic          cs0_n_q, cs0_n_d;
  logic          cs1_n_q, cs1_n_d;
  logic          rd_n_q, rd_n_d;
  logic          wr_n_q, wr_n_d;
  logic          rdy_stb_q, rdy_stb_d;
  logic          active_done;

`ifdef IDE_IORDY_EN
  localparam int EW = $clog2(IORDY_TO + 1);
  logic [EW-1:0] ext_q, ext_d;
  logic          tout_q, tout_d;

  assign active_done    = bus.ide_iordy || (ext_q == EW'(IORDY_TO));
  assign bus.iordy_tout = tout_q;
`else
  logic unused_iordy_to;
  assign unused_iordy_to = ^IORDY_TO;
  assign active_done     = 1'b1;
`endif

  // Counter is loaded with phase length minus one; zero programs as one cycle.
  function automatic logic [TW-1:0] ph_last(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    t2_d      = t2_q;
    teoc_d    = teoc_q;
    rnw_d     = rnw_q;
    ide_out_d = ide_out_q;
    rd_data_d = rd_data_q;
    ide_a_d   = ide_a_q;
    ide_dir_d = ide_dir_q;
    cs0_n_d   = cs0_n_q;
    cs1_n_d   = cs1_n_q;
    rd_n_d    = rd_n_q;
    wr_n_d    = wr_n_q;
    rdy_stb_d = 1'b0;
`ifdef IDE_IORDY_EN
    ext_d     = ext_q;
    tout_d    = tout_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.dma_req || bus.z80_req) begin
          state_d = SETUP;
          cnt_d   = ph_last(bus.t1);
          t2_d    = bus.t2;
          teoc_d  = bus.teoc;
          if (bus.dma_req) begin
            rnw_d     = bus.dma_rnw;
            ide_out_d = bus.dma_out;
            ide_a_d   = '0;
            cs0_n_d   = 1'b0;
            cs1_n_d   = 1'b1;
          end else begin
            rnw_d     = bus.z80_rnw;
            ide_out_d = bus.z80_out;
            ide_a_d   = bus.z80_a;
            cs0_n_d   = bus.z80_cs0_n;
            cs1_n_d   = bus.z80_cs1_n;
          end
          ide_dir_d = rnw_d;
`ifdef IDE_IORDY_EN
          ext_d  = '0;
          tout_d = 1'b0;
`endif
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = ACTIVE;
          cnt_d   = ph_last(t2_q);
          rd_n_d  = ~rnw_q;
          wr_n_d  = rnw_q;
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      ACTIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - TW'(1);
        end else if (active_done) begin
          state_d   = RECOVER;
          cnt_d     = ph_last(teoc_q);
          rd_n_d    = 1'b1;
          wr_n_d    = 1'b1;
          rdy_stb_d = (ph_last(teoc_q) == '0);
          if (rnw_q) rd_data_d = bus.ide_in;
`ifdef IDE_IORDY_EN
          if (!bus.ide_iordy) tout_d = 1'b1;
`endif
        end
`ifdef IDE_IORDY_EN
        else begin
          ext_d = ext_q + EW'(1);
        end
`endif
      end
      RECOVER: begin
        // Select lines survive exactly one recovery cycle before release.
        cs0_n_d   = 1'b1;
        cs1_n_d   = 1'b1;
        ide_a_d   = '0;
        ide_dir_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d     = cnt_q - TW'(1);
          rdy_stb_d = (cnt_q == TW'(1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      t2_q      <= '0;
      teoc_q    <= '0;
      rnw_q     <= 1'b0;
      ide_out_q <= '0;
      rd_data_q <= '0;
      ide_a_q   <= '0;
      ide_dir_q <= 1'b1;
      cs0_n_q   <= 1'b1;
      cs1_n_q   <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      rdy_stb_q <= 1'b0;
`ifdef IDE_IORDY_EN
      ext_q     <= '0;
      tout_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      t2_q      <= t2_d;
      teoc_q    <= teoc_d;
      rnw_q     <= rnw_d;
      ide_out_q <= ide_out_d;
      rd_data_q <= rd_data_d;
      ide_a_q   <= ide_a_d;
      ide_dir_q <= ide_dir_d;
      cs0_n_q   <= cs0_n_d;
      cs1_n_q   <= cs1_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      rdy_stb_q <= rdy_stb_d;
`ifdef IDE_IORDY_EN
      ext_q     <= ext_d;
      tout_q    <= tout_d;
`endif
    end
  end

  assign bus.rdy       = (state_q == IDLE);
  assign bus.rdy_stb   = rdy_stb_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.ide_out   = ide_out_q;
  assign bus.ide_a     = ide_a_q;
  assign bus.ide_dir   = ide_dir_q;
  assign bus.ide_cs0_n = cs0_n_q;
  assign bus.ide_cs1_n = cs1_n_q;
  assign bus.ide_rd_n  = rd_n_q;
  assign bus.ide_wr_n  = wr_n_q;

endmodule

`default_nettype wire

// File: doc/ide_pio_timed.md
Name: ide_pio_timed

Overview:
- Parametrised, runtime-timed successor to the fixed-shift-chain IDE PIO engine.
- Arbitrates one IDE bus cycle at a time between the DMA and Z80 request ports. DMA has priority.
- Runs each cycle through programmable setup, strobe and recovery phases. Latches read data from the drive.
- Sits between the DMA/Z80 port logic and the IDE pins.

Parameters:
- DW, 16, data bus width.
- AW, 3, IDE register address width.
- TW, 4, width of the timing fields and the phase counter.
- IORDY_TO, 255, IORDY wait timeout in cycles (used only with IDE_IORDY_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- t1  in  TW  setup cycles (address/CS to strobe).
- t2  in  TW  strobe-low cycles.
- teoc  in  TW  recovery cycles.
- rdy  out  1  engine idle; a new request is accepted this cycle.
- rdy_stb  out  1  one-cycle pulse in the last cycle of a transaction.
- rd_data  out  DW  data captured on read cycles.
- dma_req  in  1  DMA request.
- dma_rnw  in  1  DMA direction (1 = read).
- dma_out  in  DW  DMA write data.
- z80_req  in  1  Z80 request.
- z80_rnw  in  1  Z80 direction (1 = read).
- z80_out  in  DW  Z80 write data.
- z80_a  in  AW  Z80 register address.
- z80_cs0_n  in  1  Z80 CS0 select.
- z80_cs1_n  in  1  Z80 CS1 select.
- ide_in  in  DW  data from the IDE bus.
- ide_out  out  DW  data to the IDE bus.
- ide_a  out  AW  IDE address.
- ide_dir  out  1  bus direction, 1 = read/tristate.
- ide_cs0_n  out  1  IDE CS0.
- ide_cs1_n  out  1  IDE CS1.
- ide_rd_n  out  1  IDE read strobe.
- ide_wr_n  out  1  IDE write strobe.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state IDLE, counter 0;
  - ide_dir=1, ide_cs0_n=1, ide_cs1_n=1, ide_rd_n=1, ide_wr_n=1;
  - ide_a=0, ide_out=0, rd_data=0, rdy_stb=0.
- rdy is combinational: 1 exactly when state is IDLE.
- States: IDLE -> SETUP -> ACTIVE -> RECOVER -> IDLE.
- Each phase lasts max(tX,1) cycles; a programmed value of 0 is treated as 1.
- t1, t2 and teoc are sampled at go. Changes made mid-transaction do not affect the current transaction.
- go = rdy & (dma_req | z80_req).
- Arbitration at go: dma_req wins over z80_req. The loser's request stays pending and is not dropped.
- At go, the following are registered:
  - source, direction, write data and address;
  - DMA selects a=0, cs0_n=0, cs1_n=1;
  - Z80 selects z80_a, z80_cs0_n, z80_cs1_n.
- On the edge that accepts go: state becomes SETUP, and ide_dir, ide_cs*_n, ide_a and ide_out are driven.
- SETUP end: ide_rd_n=~rnw and ide_wr_n=rnw; state becomes ACTIVE.
- ACTIVE end (read cycle): ide_in is registered into rd_data on the edge that ends ACTIVE. rd_data holds until the next read.
- ACTIVE end (all cycles): both strobes go to 1; state becomes RECOVER.
- RECOVER:
  - ide_cs*_n, ide_a and ide_dir are held through the first RECOVER cycle, then released to idle values. ide_dir=1 on release.
  - ide_out is held until the next go.
- rdy_stb=1 in the last RECOVER cycle only. rdy rises on the following cycle.
- Latency from the go edge to rdy=1: max(t1,1)+max(t2,1)+max(teoc,1) cycles. Defaults 1/2/2 give 5 cycles.
- If go occurs in the same cycle rdy rises, the next transaction starts with no dead cycle.
- Strobes never assert while CS is inactive. ide_dir never changes while a strobe is low.
- Write data (ide_out) is stable from SETUP through RECOVER.

Optional Feature:
- Macro: IDE_IORDY_EN.
- When defined:
  - adds input ide_iordy (1 bit) and output iordy_tout (1 bit, sticky, cleared at the next go);
  - once the ACTIVE count expires, ACTIVE is extended while ide_iordy=0;
  - after IORDY_TO extension cycles, ACTIVE ends anyway and iordy_tout=1;
  - rd_data is sampled on the edge that ends the extended ACTIVE.
- When undefined: both ports are absent and ACTIVE is purely counted.

Test Plan:
- Z80 write, a=3, cs0_n=0, data 16'hA55A, t1=1/t2=2/teoc=2:
  - ide_wr_n low exactly 2 cycles, starting 1 cycle after CS falls;
  - rdy_stb pulses at cycle 5; rdy=1 at cycle 6;
  - ide_out=A55A throughout.
- DMA read, rnw=1, ide_in=16'h1234 during ACTIVE:
  - ide_a=0, cs0_n=0, cs1_n=1, ide_rd_n low for t2 cycles;
  - rd_data=1234 by the cycle rdy_stb=1.
- dma_req and z80_req both asserted while idle:
  - DMA transaction runs first;
  - Z80 transaction starts in the cycle rdy returns to 1;
  - total time = 2 x transaction length.
- t1=0, t2=0, teoc=0: transaction lasts 3 cycles. Change t2 to 5 mid-SETUP: the current strobe still lasts 1 cycle.
- reset asserted in the second ACTIVE cycle of a write:
  - strobes and CS go to 1 asynchronously, before the next edge;
  - rdy=1 after reset deasserts;
  - no rdy_stb pulse.
- IDE_IORDY_EN:
  - ide_iordy held 0 for 4 cycles past the t2 expiry: strobe length becomes t2+4, iordy_tout=0;
  - ide_iordy held 0 forever: ACTIVE ends after IORDY_TO extension cycles and iordy_tout=1.
